// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, default widths, requester indices.
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arbiter.sv).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector for the two requesters.
// MEM_ARB_ROUND_ROBIN_EN defined: contention goes to the loser of the last grant; otherwise requester 0 wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant,
    output logic any_valid
);

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        grant     = REQ0;
        any_valid = valid0 | valid1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = REQ1;
        end
`else
        if (!valid0 && valid1) begin
            grant = REQ1;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the 4x8 register memory; each transaction runs IDLE -> ISSUE -> RESP.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin contention; undefined gives requester 0 fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,

    output logic              busy
);

    state_t state, state_next;

    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_grant;

    logic grant;
    logic any_valid;
    logic accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    mem_arb_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any_valid  (any_valid)
    );

    // Starts at requester 1 so requester 0 wins the first contest.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant <= REQ1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end
`else
    mem_arb_pick u_pick (
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .grant     (grant),
        .any_valid (any_valid)
    );
`endif

    // Ready is only ever raised for a requester whose valid is high, so either ready means a handshake.
    assign accept = req0_ready | req1_ready;
    assign busy   = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the command latch is reset too, so mem_addr stays clean if reset lands mid-transaction.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_grant <= REQ0;
        end else if (accept) begin
            cmd_grant <= grant;
            if (grant == REQ1) begin
                cmd_wr    <= req1_wr;
                cmd_addr  <= req1_addr;
                cmd_wdata <= req1_wdata;
            end else begin
                cmd_wr    <= req0_wr;
                cmd_addr  <= req0_addr;
                cmd_wdata <= req0_wdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_rdata = '0;
        rsp1_rdata = '0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;

        case (state)
            IDLE: begin
                // Gating on reset keeps a valid asserted during reset from being accepted.
                if (reset && any_valid) begin
                    req0_ready = (grant == REQ0);
                    req1_ready = (grant == REQ1);
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_wr     = cmd_wr;
                mem_addr   = cmd_addr;
                mem_din    = cmd_wdata;
                state_next = RESP;
            end
            RESP: begin
                mem_addr   = cmd_addr;
                state_next = IDLE;
                // A reset arriving in this cycle drops the response entirely.
                if (reset) begin
                    if (cmd_grant == REQ1) begin
                        rsp1_valid = 1'b1;
                        rsp1_rdata = cmd_wr ? '0 : mem_dout;
                    end else begin
                        rsp0_valid = 1'b1;
                        rsp0_rdata = cmd_wr ? '0 : mem_dout;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a register-memory stand-in, a transaction-timeline reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0, req0_wr = 1'b0;
    logic [1:0] req0_addr = '0;
    logic [7:0] req0_wdata = '0;
    logic       req1_valid = 1'b0, req1_wr = 1'b0;
    logic [1:0] req1_addr = '0;
    logic [7:0] req1_wdata = '0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic       mem_wr, busy;
    logic [1:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_wr    (req0_wr),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_wr    (req1_wr),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .busy       (busy)
    );

    // Stand-in for mem_cell: writes land, or the read output registers, at the clock edge.
    logic [7:0] cells [4];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) cells[i] <= 8'h00;
            mem_dout <= 8'h00;
        end else if (mem_wr) begin
            cells[mem_addr] <= mem_din;
        end else begin
            mem_dout <= cells[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a timeline of which transaction occupies the issue and response cycles.
    typedef struct packed {
        logic       v;
        logic       wr;
        logic [1:0] a;
        logic [7:0] d;
        logic       port;
        logic [7:0] rd;
    } txn_t;

    txn_t       m_iss = '0, m_rsp = '0;
    logic       m_last = 1'b1;
    logic [7:0] ref_mem [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic       m_idle, m_win, m_acc;
    logic       e_r0, e_r1, e_wr, e_v0, e_v1;
    logic [1:0] e_addr;
    logic [7:0] e_din, e_d0, e_d1;

    always @(negedge clock) begin
        if (started) begin
            m_idle = !m_iss.v && !m_rsp.v;
            if (req0_valid && req1_valid) m_win = RR ? !m_last : 1'b0;
            else                          m_win = req1_valid;
            m_acc = m_idle && reset && (req0_valid || req1_valid);
            e_r0  = m_acc && !m_win;
            e_r1  = m_acc && m_win;

            e_wr = 1'b0; e_addr = 2'd0; e_din = 8'h00;
            if (m_iss.v) begin
                e_wr = m_iss.wr; e_addr = m_iss.a; e_din = m_iss.d;
            end else if (m_rsp.v) begin
                e_addr = m_rsp.a;
            end
            e_v0 = m_rsp.v && reset && !m_rsp.port;
            e_v1 = m_rsp.v && reset &&  m_rsp.port;
            e_d0 = (e_v0 && !m_rsp.wr) ? m_rsp.rd : 8'h00;
            e_d1 = (e_v1 && !m_rsp.wr) ? m_rsp.rd : 8'h00;

            check("m_req0_ready", req0_ready, e_r0);
            check("m_req1_ready", req1_ready, e_r1);
            check("m_mem_wr",     mem_wr,     e_wr);
            check("m_mem_addr",   mem_addr,   e_addr);
            check("m_mem_din",    mem_din,    e_din);
            check("m_rsp0_valid", rsp0_valid, e_v0);
            check("m_rsp0_rdata", rsp0_rdata, e_d0);
            check("m_rsp1_valid", rsp1_valid, e_v1);
            check("m_rsp1_rdata", rsp1_rdata, e_d1);
            check("m_busy",       busy,       !m_idle);

            if (!reset) begin
                m_iss = '0; m_rsp = '0; m_last = 1'b1;
                for (int i = 0; i < 4; i++) ref_mem[i] = 8'h00;
            end else begin
                m_rsp = m_iss;
                m_iss = '0;
                if (m_acc) begin
                    m_iss.v    = 1'b1;
                    m_iss.port = m_win;
                    m_iss.wr   = m_win ? req1_wr    : req0_wr;
                    m_iss.a    = m_win ? req1_addr  : req0_addr;
                    m_iss.d    = m_win ? req1_wdata : req0_wdata;
                    m_iss.rd   = ref_mem[m_iss.a];
                    if (m_iss.wr) ref_mem[m_iss.a] = m_iss.d;
                    m_last = m_win;
                end
            end
        end
    end

    // Present a command and hold it until accepted; returns just after the accept edge (in ISSUE).
    task automatic send(input bit port, input bit wr, input logic [1:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        if (port) begin
            req1_wr = wr; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
        end else begin
            req0_wr = wr; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = port ? req1_ready : req0_ready;
        end
        if (!got) check("accept_timeout", got, 1'b1);
        @(posedge clock); #1;
        if (port) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
    endtask

    // From ISSUE: check the response in RESP, then step into the next IDLE cycle.
    task automatic expect_rsp(input string name, input bit port, input logic [7:0] data);
        @(negedge clock);
        @(negedge clock);
        check({name, "_valid"}, port ? rsp1_valid : rsp0_valid, 1'b1);
        check({name, "_rdata"}, port ? rsp1_rdata : rsp0_rdata, data);
        check({name, "_other"}, port ? rsp0_valid : rsp1_valid, 1'b0);
        @(posedge clock); #1;
    endtask

    int n_acc, n1;
    int grants [4];
    int acc_cyc [4];

    initial begin
        repeat (2) @(posedge clock);
        #1 started = 1'b1;
        @(negedge clock);
        check("reset_busy", busy, 1'b0);
        check("reset_ready0", req0_ready, 1'b0);
        check("reset_mem_wr", mem_wr, 1'b0);
        @(posedge clock); #1 reset = 1'b1;

        // Write 0xA5 to addr 2 from requester 0.
        send(0, 1, 2'd2, 8'hA5);
        @(negedge clock);
        check("wr_issue_mem_wr", mem_wr, 1'b1);
        check("wr_issue_addr", mem_addr, 2'd2);
        check("wr_issue_din", mem_din, 8'hA5);
        @(negedge clock);
        check("wr_resp_valid", rsp0_valid, 1'b1);
        check("wr_resp_rdata", rsp0_rdata, 8'h00);
        @(posedge clock); #1;

        // Requester 1 reads it back.
        send(1, 0, 2'd2, 8'h00);
        expect_rsp("raw_p1", 1, 8'hA5);

        // Both requesters valid continuously.
        req0_wr = 0; req0_addr = 2'd0; req1_wr = 0; req1_addr = 2'd1;
        req0_valid = 1; req1_valid = 1;
        n_acc = 0; n1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (req0_ready || req1_ready) begin
                if (n_acc < 4) begin
                    grants[n_acc]  = req1_ready ? 1 : 0;
                    acc_cyc[n_acc] = c;
                end
                n_acc++;
                if (req1_ready) n1++;
            end
        end
        @(posedge clock); #1;
        req0_valid = 0; req1_valid = 0;
        check("contest_accepts", n_acc, 4);
        check("contest_req1_wins", n1, RR ? 2 : 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("contest_grant%0d", k), grants[k], RR ? (k % 2) : 0);
            check($sformatf("contest_cycle%0d", k), acc_cyc[k], 3 * k);
        end

        // Requester 1 arrives while requester 0's read is in flight.
        send(0, 0, 2'd0, 8'h00);
        req1_wr = 0; req1_addr = 2'd2; req1_wdata = 8'h00; req1_valid = 1;
        @(negedge clock);
        check("late_ready_issue", req1_ready, 1'b0);
        @(posedge clock); #1;
        @(negedge clock);
        check("late_ready_resp", req1_ready, 1'b0);
        @(posedge clock); #1;
        @(negedge clock);
        check("late_ready_idle", req1_ready, 1'b1);
        @(posedge clock); #1 req1_valid = 0;
        expect_rsp("late_p1", 1, 8'hA5);

        // Reset during the response cycle of a write.
        send(0, 1, 2'd3, 8'h3C);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("rst_resp_valid", rsp0_valid, 1'b0);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_addr", mem_addr, 2'd0);
        check("rst_mem_din", mem_din, 8'h00);
        @(posedge clock); #1;

        // Cross-port read-after-write, then a cleared location.
        send(1, 1, 2'd3, 8'hFF);
        expect_rsp("w3_p1", 1, 8'h00);
        send(0, 0, 2'd3, 8'h00);
        expect_rsp("r3_p0", 0, 8'hFF);
        send(1, 0, 2'd0, 8'h00);
        expect_rsp("r0_p1", 1, 8'h00);

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the 4×8-bit register memory (`mem_cell`). It accepts read/write commands from two requesters over valid/ready handshakes and picks one per transaction. It drives the memory's `wr`/`addr_in`/`d_in` with the required timing and returns read data on a per-requester response strobe. It sits between the core's two memory clients and the single-ported storage.

## Interface
- `ADDR_W`, default 2: address width; must match memory depth of 4.
- `DATA_W`, default 8: data width.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  command present; held stable until accepted.
- `req0_ready` / `req1_ready`  out  1  command accepted when valid&&ready at the rising edge.
- `req0_wr` / `req1_wr`  in  1  1 = write, 0 = read.
- `req0_addr` / `req1_addr`  in  ADDR_W  word address.
- `req0_wdata` / `req1_wdata`  in  DATA_W  write data (ignored for reads).
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle completion strobe; no backpressure.
- `rsp0_rdata` / `rsp1_rdata`  out  DATA_W  read data; 0 for writes and when the strobe is low.
- `mem_wr`  out  1  to memory `wr`.
- `mem_addr`  out  ADDR_W  to memory `addr_in`.
- `mem_din`  out  DATA_W  to memory `d_in`.
- `mem_dout`  in  DATA_W  from memory `d_out`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on accept.
  - ISSUE → RESP unconditionally.
  - RESP → IDLE unconditionally.
  - No other transitions.
- IDLE: `reqN_ready` is combinational. It is 1 only for the granted requester, and only when that requester's valid is high. At most one ready is high. On accept, latch `wr`, `addr`, `wdata` and the grant index.
- ISSUE: `mem_addr`, `mem_wr` and `mem_din` come from the latched command. The memory writes, or registers its read output, at the end of this cycle.
- RESP:
  - `mem_addr` holds the latched address; `mem_wr` = 0; `mem_din` = 0.
  - The granted `rspN_valid` = 1 for this cycle only.
  - `rspN_rdata` = `mem_dout` for reads and 0 for writes.
- Outside ISSUE: `mem_wr` = 0. In IDLE, `mem_addr` = 0 and `mem_din` = 0.
- Arbitration with both valids high in IDLE: the grant goes to the requester that did not win last time. `last_grant` updates on every accept.
- Single valid: that requester wins regardless of `last_grant`.
- No command is accepted in ISSUE or RESP. A requester waiting there sees ready = 0 and holds its command.
- Read-after-write to the same address from either port returns the new data, because transactions are fully serialized.

## Timing
- Accept at edge E. ISSUE is the cycle after E, and RESP is the cycle after that, so `rspN_valid` is high in the second cycle after the accept edge.
- Peak throughput: one transaction per 3 cycles.
- Reset values: state IDLE, `last_grant` = 1 (requester 0 wins the first contest). All `ready`/`rsp_valid`/`rsp_rdata`/`mem_*` = 0. `busy` = 0.
- Reset asserted in ISSUE or RESP: the transaction is dropped. No response is issued, and the FSM is in IDLE on the next cycle. A write cut off in ISSUE is not guaranteed to land; the memory is cleared by the same reset.
- Reset has priority over a simultaneous valid; nothing is accepted while `reset` = 0.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration as above, with the `last_grant` register.
- Macro undefined: fixed priority, requester 0 always wins contention. `last_grant` is not implemented. Everything else is identical.

## Structure
- Shared package/header `mem_arb_pkg`:
  - state encodings: IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
  - default `ADDR_W`/`DATA_W`;
  - requester index constants.
- One sub-module: `mem_arb_pick`. It is the combinational grant selector: inputs the two valids and `last_grant`, output grant index plus any-valid. The macro selects its policy.
- The memory is instantiated by the parent, not inside this block.

## Test plan
- Reset, then req0 writes 0xA5 to addr 2. req0_ready high in the accept cycle; `mem_wr` = 1, `mem_addr` = 2, `mem_din` = 0xA5 in the next cycle; `rsp0_valid` = 1 with `rsp0_rdata` = 0 two cycles after accept.
- Then req1 reads addr 2: `rsp1_valid` = 1 with `rsp1_rdata` = 0xA5 two cycles after accept; `rsp0_valid` stays 0.
- Both valid continuously, reads of addr 0 and addr 1:
  - round-robin: grants alternate 0,1,0,1, one accept every 3 cycles;
  - macro undefined: req0 wins every time and req1_ready never rises.
- req1 raises valid during another transaction's ISSUE: req1_ready stays 0 until IDLE, then it is accepted with its command unchanged.
- Write 0x3C to addr 3, then drop `reset` low in the RESP cycle: no `rsp0_valid`; next cycle state IDLE, `busy` = 0, all `mem_*` = 0.
- Write 0xFF to addr 3, then read addr 3 back via the other port: 0xFF. Read of addr 0 after reset: 0x00.
